csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
Machine-mode CSR file and trap controller for the single-hart core. It is the parametrised successor of the basic CSR block and adds:
- mstatus MIE/MPIE/MPP handling
- mie/mip with three level-sensitive interrupt sources
- vectored mtvec mode
- illegal-CSR-access detection
- optional 64-bit mcycle/minstret counters

It sits in the execute stage. It takes one decoded CSR/system op per valid cycle, returns read data and a trap redirect to fetch.

Parameters:
Xlen, 32, datapath width; 32 or 64 only.
MHartId, 0, value returned by mhartid.
MtvecReset, 0, reset value of mtvec (BASE and MODE).
VectoredEn, 1, 1 allows mtvec MODE=1; 0 forces MODE to 0 (WARL).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
valid_i  in  1  op/instruction present this cycle; also the interrupt-acceptance boundary
csr_op_i  in  csr_op_e  OpCSRRW/RS/RC, OpEcall, OpEbreak, OpMret, other = none
rs1_data_i  in  Xlen  write operand
csr_addr_i  in  12  CSR address
rd_data_o  out  Xlen  old CSR value (combinational)
pc_i  in  Xlen  PC of the current instruction
retire_i  in  1  an instruction retires this cycle
irq_sw_i / irq_timer_i / irq_ext_i  in  1 each  level interrupt requests (MSIP/MTIP/MEIP)
raise_trap_o  out  1  redirect fetch this cycle
trap_vector_o  out  Xlen  redirect target

Behaviour:
- Reset (asynchronous, clears immediately):
  - mstatus.MIE=0, MPIE=0, MPP=2'b11
  - mie=0, mip=0, mscratch=0, mepc=0, mcause=0, mtval=0
  - mtvec=MtvecReset
  - counters=0
  - raise_trap_o=0; rd_data_o reflects registers after reset.
- Implemented registers:
  - mhartid (RO), mstatus, misa (RO, reads I plus MXL), mie, mtvec, mscratch, mepc, mcause, mtval, mip.
  - MSIP/MTIP/MEIP are RO and reflect the inputs.
  - Unimplemented addresses read 0; writes to them are ignored.
- Illegal access: CSRRW/RS/RC that targets addr[11:10]==2'b11 (read-only space) and actually writes (RW always writes; RS/RC write when rs1_data_i!=0). It traps with cause 2 and mtval=0.
- mip sampling: the irq inputs are registered into mip every cycle. An interrupt therefore becomes visible one cycle after its input rises.
- Interrupt pending: MIE && |(mie & mip). Priority among pending sources is MEI(11) > MSI(3) > MTI(7).
- Trap priority when valid_i=1: pending interrupt > illegal CSR access > ecall (cause 11) > ebreak (cause 3).
  - The winning trap suppresses any CSR write in that cycle.
  - mret with a pending interrupt: the interrupt is taken instead.
- Trap entry (registered at the next edge):
  - mepc=pc_i with bit 0 cleared
  - mcause={intr, code}, zero-extended to Xlen
  - MPIE=MIE, MIE=0, MPP=2'b11
- mret: MIE=MPIE, MPIE=1, target=mepc.
- trap_vector_o (combinational, same cycle as valid_i):
  - mret: mepc.
  - Exceptions, or MODE=0: {BASE, 2'b00}.
  - Interrupts with MODE=1: BASE + 4*code.
- raise_trap_o = valid_i and (any trap or mret), same cycle.
- Write rules:
  - CSRRW writes rs1; CSRRS writes old|rs1; CSRRC writes old&~rs1.
  - All writes take effect at the next edge.
  - mtvec bit 1 is tied 0; MODE is forced to 0 when VectoredEn=0.
  - mepc bit 0 is tied 0.
  - mstatus writes affect only MIE/MPIE; MPP is hardwired 2'b11.
- A CSR write that enables MIE takes effect from the following cycle. The write instruction itself is never interrupted by the newly enabled source.
- With valid_i=0 no architectural state changes except mip sampling and counters.

Optional Feature:
Macro CSR_COUNTERS_EN.
- Defined: 64-bit mcycle (0xB00) and minstret (0xB02).
  - When Xlen=32, also mcycleh (0xB80) and minstreth (0xB82).
  - mcycle increments every cycle; minstret increments when retire_i=1.
  - Both wrap at 2^64-1 to 0.
  - A CSR write to a counter half wins over the increment in the same cycle. That half takes the written value; the other half holds.
- Undefined: these addresses read 0 and ignore writes; no counter flops are instantiated.

Decomposition:
- csr_pkg holds:
  - csr_addr_e (all addresses above)
  - exc_code_e and irq_code_e
  - mstatus bit-index localparams (MIE=3, MPIE=7, MPP=12:11)
  - the mtvec MODE enum
- csr_op_e stays in core_pkg.
- One sub-module, csr_counter64 (increment enable, Xlen-split lo/hi write, wrap), instantiated twice under CSR_COUNTERS_EN.

Test Plan:
1. Reset asserted mid-run, with mscratch=0xDEAD and MIE=1 -> both read 0 immediately; mtvec reads MtvecReset.
2. mtvec=0x1001 (vectored), mie.MEIE=1, MIE=1; assert irq_ext_i -> trap taken in the second valid cycle, trap_vector_o=0x102C, mcause=0x8000000B, MIE=0, MPIE=1.
3. ecall at pc 0x200 with mtvec=0x100 -> raise_trap_o=1, target 0x100, mcause=11, mepc=0x200; then mret -> target 0x200, MIE restored.
4. CSRRW mhartid with rs1=5 -> trap cause 2, mhartid unchanged; CSRRS mhartid with rs1=0 -> no trap, reads MHartId.
5. irq_sw_i and irq_timer_i raised together, both enabled -> mcause code 3; then also irq_ext_i -> code 11 wins.
6. (CSR_COUNTERS_EN, Xlen=32) write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF in consecutive cycles -> counter wraps to 0; a write in the same cycle as an increment -> written value held.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: decoded operation encodings shared by the execute-stage units.
package core_pkg;

   // CSR/system operation presented to the CSR unit; OpNone (and any other
   // unlisted encoding) means no CSR/system operation this cycle.
   typedef enum logic [2:0] {
      OpNone   = 3'd0,
      OpCSRRW  = 3'd1,
      OpCSRRS  = 3'd2,
      OpCSRRC  = 3'd3,
      OpEcall  = 3'd4,
      OpEbreak = 3'd5,
      OpMret   = 3'd6
   } csr_op_e;

endpackage

// File: rtl/csr_pkg.sv
// csr_pkg: machine-mode CSR addresses, trap cause codes, mstatus bit positions
// and the mtvec MODE encoding used by csr_unit.
package csr_pkg;

   typedef enum logic [11:0] {
      CsrMstatus   = 12'h300,
      CsrMisa      = 12'h301,
      CsrMie       = 12'h304,
      CsrMtvec     = 12'h305,
      CsrMscratch  = 12'h340,
      CsrMepc      = 12'h341,
      CsrMcause    = 12'h342,
      CsrMtval     = 12'h343,
      CsrMip       = 12'h344,
      CsrMcycle    = 12'hB00,
      CsrMinstret  = 12'hB02,
      CsrMcycleh   = 12'hB80,
      CsrMinstreth = 12'hB82,
      CsrMhartid   = 12'hF14
   } csr_addr_e;

   typedef enum logic [3:0] {
      ExcIllegalInstr = 4'd2,
      ExcBreakpoint   = 4'd3,
      ExcEcallM       = 4'd11
   } exc_code_e;

   // Interrupt codes double as the bit positions in mie/mip.
   typedef enum logic [3:0] {
      IrqMsi = 4'd3,
      IrqMti = 4'd7,
      IrqMei = 4'd11
   } irq_code_e;

   localparam int unsigned MstatusMieBit  = 3;
   localparam int unsigned MstatusMpieBit = 7;
   localparam int unsigned MstatusMppLo   = 11;
   localparam int unsigned MstatusMppHi   = 12;

   typedef enum logic [1:0] {
      MtvecDirect   = 2'b00,
      MtvecVectored = 2'b01
   } mtvec_mode_e;

   // Legal MODE for a requested value: bit 1 is tied low, and vectored mode
   // only exists when the instance enables it.
   function automatic mtvec_mode_e mtvec_mode_legal(input logic [1:0] mode, input bit vectored_en);
      return (vectored_en && mode[0]) ? MtvecVectored : MtvecDirect;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter with CSR write access. With a
// 32-bit datapath the low and high halves are written separately; a write to
// either half overrides the increment for that cycle and the other half holds.
module csr_counter64 #(
   parameter int unsigned Xlen = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   input  logic            wr_lo_i,
   input  logic            wr_hi_i,
   input  logic [Xlen-1:0] wdata_i,
   output logic [63:0]     value_o
);

   logic [63:0] count_reg;

   assign value_o = count_reg;

   generate
      if (Xlen == 32) begin : g_split
         // Half-word writes win over the increment; the counter wraps naturally.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               count_reg <= '0;
            end else if (wr_lo_i || wr_hi_i) begin
               if (wr_lo_i) count_reg[31:0]  <= wdata_i[31:0];
               if (wr_hi_i) count_reg[63:32] <= wdata_i[31:0];
            end else if (inc_i) begin
               count_reg <= count_reg + 64'd1;
            end
         end
      end else begin : g_full
         logic hi_write_unused;
         assign hi_write_unused = wr_hi_i;

         // Full-width write wins over the increment; the counter wraps naturally.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               count_reg <= '0;
            end else if (wr_lo_i) begin
               count_reg <= 64'(wdata_i);
            end else if (inc_i) begin
               count_reg <= count_reg + 64'd1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap controller for the single-hart core.
// Accepts one CSR/system op per valid cycle, returns the old CSR value and a
// same-cycle trap/mret redirect. Define CSR_COUNTERS_EN to add the 64-bit
// mcycle/minstret counters (plus the high halves on a 32-bit datapath).
module csr_unit
   import core_pkg::*;
   import csr_pkg::*;
#(
   parameter int unsigned     Xlen       = 32,
   parameter logic [Xlen-1:0] MHartId    = '0,
   parameter logic [Xlen-1:0] MtvecReset = '0,
   parameter bit              VectoredEn = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   input  csr_op_e         csr_op_i,
   input  logic [Xlen-1:0] rs1_data_i,
   input  logic [11:0]     csr_addr_i,
   output logic [Xlen-1:0] rd_data_o,
   input  logic [Xlen-1:0] pc_i,
   input  logic            retire_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   output logic            raise_trap_o,
   output logic [Xlen-1:0] trap_vector_o
);

   localparam logic [Xlen-1:0] IrqMask   = Xlen'(12'h888);
   localparam logic [Xlen-1:0] MisaValue = (Xlen'((Xlen == 64) ? 2 : 1) << (Xlen - 2)) | Xlen'(32'h100);
   localparam logic [Xlen-1:0] MtvecResetLegal =
      {MtvecReset[Xlen-1:2], mtvec_mode_legal(MtvecReset[1:0], VectoredEn)};

   logic            mstatus_mie_reg, mstatus_mpie_reg;
   logic [Xlen-1:0] mie_reg, mip_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;

   logic [Xlen-1:0] mstatus_val, csr_rdata, csr_wdata, irq_active, vector_base;
   logic            csr_access, csr_writes, illegal_access, csr_we;
   logic            irq_pending, take_irq, take_exc, take_trap, take_mret;
   logic [3:0]      irq_code, exc_code, trap_code;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_val, minstret_val;
   logic        mcycle_lo_we, mcycle_hi_we, minstret_lo_we, minstret_hi_we;

   assign mcycle_lo_we   = csr_we && (csr_addr_i == CsrMcycle);
   assign mcycle_hi_we   = csr_we && (Xlen == 32) && (csr_addr_i == CsrMcycleh);
   assign minstret_lo_we = csr_we && (csr_addr_i == CsrMinstret);
   assign minstret_hi_we = csr_we && (Xlen == 32) && (csr_addr_i == CsrMinstreth);

   csr_counter64 #(.Xlen(Xlen)) u_mcycle (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (1'b1),
      .wr_lo_i (mcycle_lo_we),
      .wr_hi_i (mcycle_hi_we),
      .wdata_i (csr_wdata),
      .value_o (mcycle_val)
   );

   csr_counter64 #(.Xlen(Xlen)) u_minstret (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (retire_i),
      .wr_lo_i (minstret_lo_we),
      .wr_hi_i (minstret_hi_we),
      .wdata_i (csr_wdata),
      .value_o (minstret_val)
   );
`else
   logic retire_unused;
   assign retire_unused = retire_i;
`endif

   // mstatus view: MPP is hardwired to machine mode, only MIE/MPIE are stored.
   always_comb begin
      mstatus_val = '0;
      mstatus_val[MstatusMppHi:MstatusMppLo] = 2'b11;
      mstatus_val[MstatusMpieBit] = mstatus_mpie_reg;
      mstatus_val[MstatusMieBit]  = mstatus_mie_reg;
   end

   // Read mux: old value of the addressed CSR, zero for unimplemented addresses.
   always_comb begin
      csr_rdata = '0;
      case (csr_addr_i)
         CsrMhartid:   csr_rdata = MHartId;
         CsrMstatus:   csr_rdata = mstatus_val;
         CsrMisa:      csr_rdata = MisaValue;
         CsrMie:       csr_rdata = mie_reg;
         CsrMtvec:     csr_rdata = mtvec_reg;
         CsrMscratch:  csr_rdata = mscratch_reg;
         CsrMepc:      csr_rdata = mepc_reg;
         CsrMcause:    csr_rdata = mcause_reg;
         CsrMtval:     csr_rdata = mtval_reg;
         CsrMip:       csr_rdata = mip_reg;
`ifdef CSR_COUNTERS_EN
         CsrMcycle:    csr_rdata = mcycle_val[Xlen-1:0];
         CsrMinstret:  csr_rdata = minstret_val[Xlen-1:0];
         CsrMcycleh:   if (Xlen == 32) csr_rdata = Xlen'(mcycle_val >> 32);
         CsrMinstreth: if (Xlen == 32) csr_rdata = Xlen'(minstret_val >> 32);
`endif
         default:      csr_rdata = '0;
      endcase
   end

   assign rd_data_o = csr_rdata;

   // New CSR value for read-modify-write ops, before per-register WARL masking.
   always_comb begin
      csr_wdata = csr_rdata;
      case (csr_op_i)
         OpCSRRW: csr_wdata = rs1_data_i;
         OpCSRRS: csr_wdata = csr_rdata | rs1_data_i;
         OpCSRRC: csr_wdata = csr_rdata & ~rs1_data_i;
         default: csr_wdata = csr_rdata;
      endcase
   end

   // RS/RC with a zero operand are pure reads, so they may target read-only space.
   assign csr_access     = valid_i && (csr_op_i == OpCSRRW || csr_op_i == OpCSRRS || csr_op_i == OpCSRRC);
   assign csr_writes     = (csr_op_i == OpCSRRW) || (rs1_data_i != '0);
   assign illegal_access = csr_access && csr_writes && (csr_addr_i[11:10] == 2'b11);

   // Uses the registered MIE, so an instruction enabling MIE is never itself interrupted.
   assign irq_active  = mie_reg & mip_reg;
   assign irq_pending = mstatus_mie_reg && (|irq_active);

   // Interrupt priority: external, then software, then timer.
   always_comb begin
      irq_code = IrqMti;
      if (irq_active[IrqMei])      irq_code = IrqMei;
      else if (irq_active[IrqMsi]) irq_code = IrqMsi;
   end

   // Exception priority among synchronous causes: illegal CSR, ecall, ebreak.
   always_comb begin
      exc_code = ExcBreakpoint;
      if (illegal_access)             exc_code = ExcIllegalInstr;
      else if (csr_op_i == OpEcall)   exc_code = ExcEcallM;
   end

   assign take_irq  = valid_i && irq_pending;
   assign take_exc  = valid_i && !irq_pending &&
                      (illegal_access || csr_op_i == OpEcall || csr_op_i == OpEbreak);
   assign take_trap = take_irq || take_exc;
   assign take_mret = valid_i && !irq_pending && (csr_op_i == OpMret);
   assign trap_code = take_irq ? irq_code : exc_code;
   assign csr_we    = csr_access && csr_writes && !take_trap;

   assign raise_trap_o = take_trap || take_mret;
   assign vector_base  = {mtvec_reg[Xlen-1:2], 2'b00};

   // Redirect target: mepc for mret, BASE+4*code for vectored interrupts, else BASE.
   always_comb begin
      trap_vector_o = vector_base;
      if (take_mret) begin
         trap_vector_o = mepc_reg;
      end else if (take_irq && (mtvec_reg[1:0] == MtvecVectored)) begin
         trap_vector_o = vector_base + Xlen'({trap_code, 2'b00});
      end
   end

   // Interrupt lines are sampled every cycle regardless of valid_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) mip_reg <= '0;
      else         mip_reg <= Xlen'({irq_ext_i, 3'b000, irq_timer_i, 3'b000, irq_sw_i, 3'b000});
   end

   // mstatus: trap entry stacks MIE, mret unstacks it, otherwise CSR writes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mstatus_mie_reg  <= 1'b0;
         mstatus_mpie_reg <= 1'b0;
      end else if (take_trap) begin
         mstatus_mpie_reg <= mstatus_mie_reg;
         mstatus_mie_reg  <= 1'b0;
      end else if (take_mret) begin
         mstatus_mie_reg  <= mstatus_mpie_reg;
         mstatus_mpie_reg <= 1'b1;
      end else if (csr_we && (csr_addr_i == CsrMstatus)) begin
         mstatus_mie_reg  <= csr_wdata[MstatusMieBit];
         mstatus_mpie_reg <= csr_wdata[MstatusMpieBit];
      end
   end

   // Remaining CSRs: trap entry records mepc/mcause/mtval, else CSR writes apply.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mie_reg      <= '0;
         mtvec_reg    <= MtvecResetLegal;
         mscratch_reg <= '0;
         mepc_reg     <= '0;
         mcause_reg   <= '0;
         mtval_reg    <= '0;
      end else if (take_trap) begin
         mepc_reg   <= {pc_i[Xlen-1:1], 1'b0};
         mcause_reg <= {take_irq, {(Xlen-5){1'b0}}, trap_code};
         mtval_reg  <= '0;
      end else if (csr_we) begin
         case (csr_addr_i)
            CsrMie:      mie_reg      <= csr_wdata & IrqMask;
            CsrMtvec:    mtvec_reg    <= {csr_wdata[Xlen-1:2], mtvec_mode_legal(csr_wdata[1:0], VectoredEn)};
            CsrMscratch: mscratch_reg <= csr_wdata;
            CsrMepc:     mepc_reg     <= {csr_wdata[Xlen-1:1], 1'b0};
            CsrMcause:   mcause_reg   <= csr_wdata;
            CsrMtval:    mtval_reg    <= csr_wdata;
            default:     ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scoreboard bench for csr_unit (Xlen=32, MHartId=3,
// MtvecReset=0x80, vectored mode enabled). The driver pushes the expected
// response for every op it issues; a negedge monitor pops and compares.
module tb_csr_unit;
   import core_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   csr_op_e     csr_op_i;
   logic [31:0] rs1_data_i;
   logic [11:0] csr_addr_i;
   logic [31:0] rd_data_o;
   logic [31:0] pc_i;
   logic        retire_i;
   logic        irq_sw_i, irq_timer_i, irq_ext_i;
   logic        raise_trap_o;
   logic [31:0] trap_vector_o;

   typedef struct {
      string       name;
      bit          chk_rd;
      logic [31:0] rd;
      bit          trap;
      logic [31:0] vec;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   csr_unit #(
      .Xlen       (32),
      .MHartId    (32'h3),
      .MtvecReset (32'h80),
      .VectoredEn (1'b1)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .csr_op_i      (csr_op_i),
      .rs1_data_i    (rs1_data_i),
      .csr_addr_i    (csr_addr_i),
      .rd_data_o     (rd_data_o),
      .pc_i          (pc_i),
      .retire_i      (retire_i),
      .irq_sw_i      (irq_sw_i),
      .irq_timer_i   (irq_timer_i),
      .irq_ext_i     (irq_ext_i),
      .raise_trap_o  (raise_trap_o),
      .trap_vector_o (trap_vector_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cmp(input string what, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h required %h", nm, what, act, exp);
      end
   endtask

   // Monitor: every valid cycle is one response; pop its expectation and compare.
   always @(negedge clk_i) begin
      if (valid_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got a valid op, required an empty scoreboard");
         end else begin
            mon_e = exp_q.pop_front();
            $display("txn %s trap=%0b vec=%h rd=%h", mon_e.name, raise_trap_o, trap_vector_o, rd_data_o);
            cmp("trap", mon_e.name, {31'b0, raise_trap_o}, {31'b0, mon_e.trap});
            if (mon_e.trap) cmp("vector", mon_e.name, trap_vector_o, mon_e.vec);
            if (mon_e.chk_rd) cmp("rd", mon_e.name, rd_data_o, mon_e.rd);
         end
      end
   end

   task automatic issue(input string nm, input csr_op_e op, input logic [11:0] addr, input logic [31:0] data,
                        input logic [31:0] pc, input bit chk_rd, input logic [31:0] exp_rd,
                        input bit exp_trap, input logic [31:0] exp_vec);
      exp_t e;
      e.name = nm; e.chk_rd = chk_rd; e.rd = exp_rd; e.trap = exp_trap; e.vec = exp_vec;
      exp_q.push_back(e);
      valid_i = 1'b1; csr_op_i = op; csr_addr_i = addr; rs1_data_i = data; pc_i = pc;
      @(posedge clk_i); #1;
      valid_i = 1'b0; csr_op_i = OpNone; rs1_data_i = '0; csr_addr_i = '0;
   endtask

   task automatic rd_csr(input string nm, input logic [11:0] a, input logic [31:0] v);
      issue(nm, OpCSRRS, a, 32'h0, 32'h0, 1'b1, v, 1'b0, 32'h0);
   endtask

   task automatic wr_csr(input string nm, input csr_op_e op, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] old);
      issue(nm, op, a, d, 32'h0, 1'b1, old, 1'b0, 32'h0);
   endtask

   // Watchdog so the run always ends even if the clocked driver stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, required completion within time limit");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus; values in comments are the hand-derived CSR state.
   initial begin
      rst_ni = 1'b0; valid_i = 1'b0; csr_op_i = OpNone; rs1_data_i = '0; csr_addr_i = '0;
      pc_i = '0; retire_i = 1'b0; irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Reset values.
      rd_csr("rst_mstatus", 12'h300, 32'h0000_1800);
      rd_csr("rst_mtvec",   12'h305, 32'h0000_0080);
      rd_csr("rst_misa",    12'h301, 32'h4000_0100);
      rd_csr("rst_mhartid", 12'hF14, 32'h0000_0003);

      // Reset mid-run clears mscratch and MIE immediately.
      wr_csr("w_mscratch",  OpCSRRW, 12'h340, 32'h0000_DEAD, 32'h0);
      wr_csr("set_mie",     OpCSRRS, 12'h300, 32'h8, 32'h1800);
      rd_csr("r_mscratch",  12'h340, 32'h0000_DEAD);
      rd_csr("r_mstatus",   12'h300, 32'h1808);
      rst_ni = 1'b0;
      rd_csr("inrst_mscratch", 12'h340, 32'h0);
      rd_csr("inrst_mstatus",  12'h300, 32'h1800);
      rd_csr("inrst_mtvec",    12'h305, 32'h80);
      rst_ni = 1'b1;

      // ecall / ebreak / mret with direct mtvec.
      wr_csr("w_mtvec100", OpCSRRW, 12'h305, 32'h100, 32'h80);
      wr_csr("set_mie2",   OpCSRRS, 12'h300, 32'h8, 32'h1800);
      issue("ecall",       OpEcall, 12'h0, 32'h0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h100);
      rd_csr("ecall_mcause",  12'h342, 32'hB);
      rd_csr("ecall_mepc",    12'h341, 32'h200);
      rd_csr("ecall_mstatus", 12'h300, 32'h1880);
      issue("mret1",       OpMret, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
      rd_csr("mret1_mstatus", 12'h300, 32'h1888);
      issue("ebreak",      OpEbreak, 12'h0, 32'h0, 32'h301, 1'b0, 32'h0, 1'b1, 32'h100);
      rd_csr("ebreak_mcause", 12'h342, 32'h3);
      rd_csr("ebreak_mepc",   12'h341, 32'h300);
      issue("mret2",       OpMret, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300);

      // Illegal writes to read-only space.
      wr_csr("w_mtval",    OpCSRRW, 12'h343, 32'h55, 32'h0);
      issue("ill_rw_hart", OpCSRRW, 12'hF14, 32'h5, 32'h400, 1'b1, 32'h3, 1'b1, 32'h100);
      rd_csr("ill_mcause", 12'h342, 32'h2);
      rd_csr("ill_mtval",  12'h343, 32'h0);
      rd_csr("rs0_hart",   12'hF14, 32'h3);
      wr_csr("rc0_hart",   OpCSRRC, 12'hF14, 32'h0, 32'h3);
      issue("ill_rs_hart", OpCSRRS, 12'hF14, 32'h1, 32'h404, 1'b1, 32'h3, 1'b1, 32'h100);
      rd_csr("ill2_mstatus", 12'h300, 32'h1800);
      wr_csr("w_mepc_odd", OpCSRRW, 12'h341, 32'h403, 32'h404);
      rd_csr("r_mepc_even", 12'h341, 32'h402);
      wr_csr("w_mtvec_vec", OpCSRRW, 12'h305, 32'h1003, 32'h100);
      rd_csr("r_mtvec_vec", 12'h305, 32'h1001);

      // External interrupt, vectored: taken in the second valid cycle.
      wr_csr("w_mie_mei",  OpCSRRW, 12'h304, 32'h800, 32'h0);
      wr_csr("set_mie3",   OpCSRRS, 12'h300, 32'h8, 32'h1800);
      irq_ext_i = 1'b1;
      rd_csr("irq_first",  12'h340, 32'h0);
      issue("irq_take",    OpCSRRS, 12'h340, 32'h0, 32'h500, 1'b1, 32'h0, 1'b1, 32'h102C);
      rd_csr("irq_mcause",  12'h342, 32'h8000_000B);
      rd_csr("irq_mstatus", 12'h300, 32'h1880);
      rd_csr("irq_mepc",    12'h341, 32'h500);
      rd_csr("irq_mip",     12'h344, 32'h800);
      wr_csr("mie_wr_noirq", OpCSRRS, 12'h300, 32'h8, 32'h1880);
      issue("irq_after_en", OpCSRRS, 12'h340, 32'h0, 32'h600, 1'b1, 32'h0, 1'b1, 32'h102C);
      irq_ext_i = 1'b0;
      rd_csr("mip_lag",    12'h344, 32'h800);
      rd_csr("mip_clear",  12'h344, 32'h0);

      // Software+timer together: MSI wins; then external beats both.
      wr_csr("w_mie_all",  OpCSRRW, 12'h304, 32'h888, 32'h800);
      irq_sw_i = 1'b1; irq_timer_i = 1'b1;
      wr_csr("set_mie4",   OpCSRRS, 12'h300, 32'h8, 32'h1880);
      issue("irq_msi",     OpCSRRS, 12'h340, 32'h0, 32'h700, 1'b1, 32'h0, 1'b1, 32'h100C);
      rd_csr("msi_mcause", 12'h342, 32'h8000_0003);
      irq_ext_i = 1'b1;
      wr_csr("set_mie5",   OpCSRRS, 12'h300, 32'h8, 32'h1880);
      issue("irq_mei",     OpCSRRS, 12'h340, 32'h0, 32'h704, 1'b1, 32'h0, 1'b1, 32'h102C);
      rd_csr("mei_mcause", 12'h342, 32'h8000_000B);
      irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
      wr_csr("w_mie_0",    OpCSRRW, 12'h304, 32'h0, 32'h888);

      // Exceptions are not vectored even with MODE=1.
      issue("ecall_vec",   OpEcall, 12'h0, 32'h0, 32'h800, 1'b0, 32'h0, 1'b1, 32'h1000);
      rd_csr("ecall_vec_mstatus", 12'h300, 32'h1800);
      issue("mret3",       OpMret, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800);
      rd_csr("mret3_mstatus", 12'h300, 32'h1880);

`ifdef CSR_COUNTERS_EN
      // Counter wrap and write-over-increment.
      issue("w_mcycle_lo", OpCSRRW, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      issue("w_mcycle_hi", OpCSRRW, 12'hB80, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      rd_csr("mcycle_max",  12'hB00, 32'hFFFF_FFFF);
      rd_csr("mcycle_wrap", 12'hB00, 32'h0);
      rd_csr("mcycleh_wrap", 12'hB80, 32'h0);
      wr_csr("w_mcycle_50", OpCSRRW, 12'hB00, 32'h50, 32'h2);
      rd_csr("mcycle_held", 12'hB00, 32'h50);
      retire_i = 1'b1;
      wr_csr("w_minstret",  OpCSRRW, 12'hB02, 32'h10, 32'h0);
      rd_csr("minstret_held", 12'hB02, 32'h10);
      retire_i = 1'b0;
      rd_csr("minstret_inc", 12'hB02, 32'h11);
      rd_csr("minstreth",    12'hB82, 32'h0);
`else
      // Without counters the addresses read zero and ignore writes.
      rd_csr("mcycle_absent",  12'hB00, 32'h0);
      wr_csr("w_mcycle_absent", OpCSRRW, 12'hB00, 32'h5, 32'h0);
      rd_csr("mcycle_still0",  12'hB00, 32'h0);
      rd_csr("minstreth_absent", 12'hB82, 32'h0);
`endif

      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
